// File: rtl/md_unit_ctrl_pkg.sv
// md_unit_ctrl_pkg: op codes, FSM state codes and op classification for the mult/div unit
package md_unit_ctrl_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  // ops that occupy the unit for several cycles; the madd family only exists when it is built
  function automatic logic is_long_op(input logic [3:0] op);
`ifdef MD_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
  endfunction
endpackage

// File: rtl/md_unit_ctrl_arith.sv
// md_unit_ctrl_arith: combinational 64-bit {hi,lo} result of a mult/div op (madd family with MD_MADD_EN)
module md_unit_ctrl_arith import md_unit_ctrl_pkg::*; (
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
`ifdef MD_MADD_EN
  input  logic [63:0] acc,
`endif
  output logic [63:0] res
);
  logic [63:0] prod_s, prod_u, sdiv, udiv, ext;
  logic [31:0] dv, q_s, r_s;
  logic        ovf;
  // the divisor is forced to 1 for the zero and overflow cases so the divider never sees them
  always_comb begin
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'd0, rs} * {32'd0, rt};
    ovf = (rs == 32'h8000_0000) & (rt == 32'hFFFF_FFFF);
    dv = (rt == 32'd0 || ovf) ? 32'd1 : rt;
    q_s = 32'($signed(rs) / $signed(dv));
    r_s = 32'($signed(rs) % $signed(dv));
    sdiv = (rt == 32'd0) ? {rs, 32'hFFFF_FFFF} : ovf ? {32'd0, 32'h8000_0000} : {r_s, q_s};
    udiv = (rt == 32'd0) ? {rs, 32'hFFFF_FFFF} : {rs % dv, rs / dv};
`ifdef MD_MADD_EN
    ext = (op == MD_MADD) ? acc + prod_s : (op == MD_MADDU) ? acc + prod_u :
          (op == MD_MSUB) ? acc - prod_s : (op == MD_MSUBU) ? acc - prod_u : 64'd0;
`else
    ext = 64'd0;
`endif
    res = (op == MD_MULT) ? prod_s : (op == MD_MULTU) ? prod_u :
          (op == MD_DIV) ? sdiv : (op == MD_DIVU) ? udiv : ext;
  end
endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: sequences the EX-stage mult/div unit and owns HI/LO; MD_MADD_EN adds madd/msub
module md_unit_ctrl import md_unit_ctrl_pkg::*; #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        id_uses_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d, arith_res;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        idle, accept, commit;
  md_unit_ctrl_arith u_arith (
    .op  (md_op),
    .rs  (rs_val),
    .rt  (rt_val),
`ifdef MD_MADD_EN
    .acc ({hi_q, lo_q}),
`endif
    .res (arith_res)
  );
  // result is computed and parked at the start edge; hi/lo only change on mthi/mtlo or at commit
  always_comb begin
    idle = state_q == S_IDLE;
    accept = idle & md_start & is_long_op(md_op);
    commit = (state_q == S_RUN) & (cnt_q == 4'd1);
    state_d = accept ? S_RUN : commit ? S_IDLE : state_q;
    cnt_d = accept ? ((md_op == MD_DIV || md_op == MD_DIVU) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) :
            (state_q == S_RUN) ? cnt_q - 4'd1 : cnt_q;
    res_d = accept ? arith_res : res_q;
    hi_d = commit ? res_q[63:32] : (idle & md_start & md_op == MD_MTHI) ? rs_val : hi_q;
    lo_d = commit ? res_q[31:0] : (idle & md_start & md_op == MD_MTLO) ? rs_val : lo_q;
  end
  // state registers; reset drops any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      res_q <= 64'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q == S_RUN;
  assign stall_req = id_uses_md & (busy | (md_start & is_long_op(md_op)));
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed vectors checked against a cycle-level behavioural model of md_unit_ctrl
module tb_md_unit_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0, reset = 1'b1, md_start = 1'b0, id_uses_md = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;
  int checks = 0, passes = 0, cyc = 0;
  bit armed = 1'b0;
  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op), .rs_val(rs_val),
    .rt_val(rt_val), .id_uses_md(id_uses_md), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask
  // model: remaining busy cycles, pending {hi,lo}, architectural hi/lo
  int m_left = 0;
  logic [63:0] m_pend = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  function automatic bit m_long(input logic [3:0] op);
`ifdef MD_MADD_EN
    return op >= 1 && op <= 10 && op != 5 && op != 6;
`else
    return op >= 1 && op <= 4;
`endif
  endfunction
  function automatic logic [63:0] m_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint an, bn, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    an = a[31] ? -longint'($signed(a)) : longint'(a);
    bn = b[31] ? -longint'($signed(b)) : longint'(b);
    q = an / bn;
    r = an % bn;
    if (a[31] != b[31]) q = -q;
    if (a[31]) r = -r;
    return {r[31:0], q[31:0]};
  endfunction
  function automatic logic [63:0] m_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] acc);
    longint ps;
    logic [63:0] pu;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = 64'(a) * 64'(b);
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: return m_div(a, b, 1'b1);
      4'd4: return m_div(a, b, 1'b0);
      4'd7: return acc + ps;
      4'd8: return acc + pu;
      4'd9: return acc - ps;
      default: return acc - pu;
    endcase
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_left = 0; m_pend = 0; m_hi = 0; m_lo = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (md_start) begin
      if (m_long(md_op)) begin
        m_pend = m_calc(md_op, rs_val, rt_val, {m_hi, m_lo});
        m_left = (md_op == 3 || md_op == 4) ? DC : MC;
      end else if (md_op == 5) m_hi = rs_val;
      else if (md_op == 6) m_lo = rs_val;
    end
  end
  // per-cycle comparison against the model
  always @(negedge clk) if (armed) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("stall_req", 32'(stall_req), 32'(id_uses_md && (m_left > 0 || (md_start && m_long(md_op)))));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int t);
    @(posedge clk); #1;
    md_start = 1'b1; md_op = op; rs_val = a; rt_val = b; t = cyc;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 4'd0; rs_val = $urandom; rt_val = $urandom;
  endtask
  task automatic at(input int t);
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (cyc >= t) return;
    end
    chk("wait_timeout", 32'(cyc), 32'(t));
  endtask
  task automatic settle();
    for (int g = 0; g < 40 && m_left > 0; g++) @(posedge clk);
    @(posedge clk); #1;
  endtask
  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    issue(4'd1, -32'sd3, 32'd7, t);
    at(t + 1); chk("mult_busy_first", 32'(busy), 32'd1);
    at(t + 5); chk("mult_busy_last", 32'(busy), 32'd1); chk("mult_lo_not_yet", lo, 32'd0);
    at(t + 6); chk("mult_busy_done", 32'(busy), 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFEB);
    id_uses_md = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b1; md_op = 4'd4; rs_val = 32'd100; rt_val = 32'd7; t = cyc;
    @(negedge clk); chk("divu_stall_T", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 4'd0; rs_val = 32'd1; rt_val = 32'd1;
    at(t + 10); chk("divu_stall_T10", 32'(stall_req), 32'd1);
    at(t + 11); chk("divu_stall_T11", 32'(stall_req), 32'd0);
    chk("divu_lo", lo, 32'd14); chk("divu_hi", hi, 32'd2);
    id_uses_md = 1'b0;
    issue(4'd3, -32'sd7, 32'd2, t);
    at(t + DC + 1); chk("div_neg_lo", lo, 32'hFFFF_FFFD); chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    issue(4'd3, 32'd5, 32'd0, t);
    at(t + DC + 1); chk("div0_lo", lo, 32'hFFFF_FFFF); chk("div0_hi", hi, 32'd5);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, t);
    at(t + DC + 1); chk("divovf_lo", lo, 32'h8000_0000); chk("divovf_hi", hi, 32'd0);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    at(t + MC + 1); chk("multu_hi", hi, 32'hFFFF_FFFE); chk("multu_lo", lo, 32'd1);
    issue(4'd4, 32'd7, 32'd0, t);
    settle();
    @(posedge clk); #1;
    md_start = 1'b1; md_op = 4'd5; rs_val = 32'hDEAD_BEEF; t = cyc;
    @(posedge clk); #1;
    md_op = 4'd6; rs_val = 32'd1;
    @(negedge clk); chk("mthi_busy", 32'(busy), 32'd0); chk("mthi_hi", hi, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 4'd0;
    @(negedge clk); chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_hi", hi, 32'hDEAD_BEEF); chk("mtlo_lo", lo, 32'd1);
    issue(4'd0, 32'd9, 32'd9, t);
    @(negedge clk); chk("none_busy", 32'(busy), 32'd0);
    issue(4'd11, 32'd9, 32'd9, t);
    @(negedge clk); chk("undef_busy", 32'(busy), 32'd0);
`ifndef MD_MADD_EN
    issue(4'd7, 32'd9, 32'd9, t);
    @(negedge clk); chk("madd_off_busy", 32'(busy), 32'd0);
`endif
    issue(4'd3, 32'd50, 32'd3, t);
    at(t + 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    at(t + 4); chk("rst_busy", 32'(busy), 32'd0); chk("rst_hi", hi, 32'd0); chk("rst_lo", lo, 32'd0);
    at(t + DC + 3); chk("rst_no_commit_lo", lo, 32'd0);
`ifdef MD_MADD_EN
    issue(4'd6, 32'd10, 32'd0, t);
    issue(4'd7, 32'd2, 32'd3, t);
    at(t + MC + 1); chk("madd_lo", lo, 32'd16); chk("madd_hi", hi, 32'd0);
    issue(4'd10, 32'd1, 32'd20, t);
    at(t + MC + 1); chk("msubu_hi", hi, 32'hFFFF_FFFF); chk("msubu_lo", lo, 32'hFFFF_FFFC);
    issue(4'd9, -32'sd2, 32'd3, t);
    settle();
    issue(4'd8, 32'hFFFF_FFFF, 32'd2, t);
    settle();
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    armed = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
